// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD hh:mm:ss register bank with tick cascade, pending-tick buffer and field load path
module bcd_increment_16bit (
  input  logic [15:0] bcd_in,
  input  logic [15:0] bcd_max,
  output logic [15:0] bcd_out
);
  logic [15:0] sum;
  logic        c;
  // ripple a +1 through four BCD digits, then fold the wrap value back to zero
  always_comb begin
    c = 1'b1;
    sum = bcd_in;
    for (int i = 0; i < 4; i++) begin
      sum[4*i +: 4] = c ? ((bcd_in[4*i +: 4] == 4'd9) ? 4'd0 : bcd_in[4*i +: 4] + 4'd1) : bcd_in[4*i +: 4];
      c = c & (bcd_in[4*i +: 4] == 4'd9);
    end
    bcd_out = (sum == bcd_max) ? 16'h0000 : sum;
  end
endmodule

module bcd_time_counter #(
  parameter logic [7:0] HOUR_MAX  = 8'h24,
  parameter logic [7:0] INIT_SEC  = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00,
  parameter logic [7:0] INIT_HOUR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [7:0] set_val,
  output logic       set_ack,
  output logic       set_err,
  output logic       tick_lost,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       min_carry,
  output logic       hour_carry,
  output logic       day_carry
);
  logic [15:0] sec_inc, min_inc, hour_inc;
  logic        sec_wrap, min_wrap, hour_wrap;
  logic        tick_pend, apply, set_valid, load;
  logic [7:0]  limit;

  bcd_increment_16bit u_sec  (.bcd_in({8'h00, sec}),  .bcd_max(16'h0060),           .bcd_out(sec_inc));
  bcd_increment_16bit u_min  (.bcd_in({8'h00, min}),  .bcd_max(16'h0060),           .bcd_out(min_inc));
  bcd_increment_16bit u_hour (.bcd_in({8'h00, hour}), .bcd_max({8'h00, HOUR_MAX}), .bcd_out(hour_inc));

  assign sec_wrap  = ~|sec_inc;
  assign min_wrap  = ~|min_inc;
  assign hour_wrap = ~|hour_inc;
  assign apply     = (tick | tick_pend) & ~set_en;
  assign limit     = (set_sel == 2'd2) ? HOUR_MAX : 8'h60;
  assign set_valid = (set_sel != 2'd3) && (set_val[7:4] <= 4'd9) && (set_val[3:0] <= 4'd9) && (set_val < limit);
  assign load      = set_en & set_valid;

  // count on applied ticks, load on accepted sets, buffer one tick while set_en holds counting off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec        <= INIT_SEC;
      min        <= INIT_MIN;
      hour       <= INIT_HOUR;
      tick_pend  <= 1'b0;
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
      tick_lost  <= 1'b0;
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_carry  <= 1'b0;
    end else begin
      set_ack    <= load;
      set_err    <= set_en & ~set_valid;
      tick_lost  <= tick & tick_pend;
      tick_pend  <= set_en & (tick | tick_pend);
      min_carry  <= apply & sec_wrap;
      hour_carry <= apply & sec_wrap & min_wrap;
      day_carry  <= apply & sec_wrap & min_wrap & hour_wrap;
      sec        <= apply ? sec_inc[7:0] : (load && set_sel == 2'd0) ? set_val : sec;
      min        <= (apply && sec_wrap) ? min_inc[7:0] : (load && set_sel == 2'd1) ? set_val : min;
      hour       <= (apply && sec_wrap && min_wrap) ? hour_inc[7:0] : (load && set_sel == 2'd2) ? set_val : hour;
    end
  end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed plus random stimulus against a decimal time-of-day model, two hour ranges
module tb_bcd_time_counter;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, set_en = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic [7:0] set_val = 8'h00;
  logic       ack_o[2], err_o[2], lost_o[2], mc_o[2], hc_o[2], dc_o[2];
  logic [7:0] sec_o[2], min_o[2], hour_o[2];
  int total = 0, bad = 0;
  int hmax[2] = '{24, 12};
  int is[2] = '{0, 45}, im[2] = '{0, 30}, ih[2] = '{0, 5};
  int ms[2], mm[2], mh[2];
  bit mp[2], e_ack[2], e_err[2], e_lost[2], e_mc[2], e_hc[2], e_dc[2];
  int cnt;

  bcd_time_counter #(.HOUR_MAX(8'h24)) u0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_en(set_en), .set_sel(set_sel), .set_val(set_val),
    .set_ack(ack_o[0]), .set_err(err_o[0]), .tick_lost(lost_o[0]), .sec(sec_o[0]), .min(min_o[0]),
    .hour(hour_o[0]), .min_carry(mc_o[0]), .hour_carry(hc_o[0]), .day_carry(dc_o[0]));
  bcd_time_counter #(.HOUR_MAX(8'h12), .INIT_SEC(8'h45), .INIT_MIN(8'h30), .INIT_HOUR(8'h05)) u1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_en(set_en), .set_sel(set_sel), .set_val(set_val),
    .set_ack(ack_o[1]), .set_err(err_o[1]), .tick_lost(lost_o[1]), .sec(sec_o[1]), .min(min_o[1]),
    .hour(hour_o[1]), .min_carry(mc_o[1]), .hour_carry(hc_o[1]), .day_carry(dc_o[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int x);
    return 8'((x / 10) * 16 + x % 10);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = is[k]; mm[k] = im[k]; mh[k] = ih[k]; mp[k] = 0;
      e_ack[k] = 0; e_err[k] = 0; e_lost[k] = 0; e_mc[k] = 0; e_hc[k] = 0; e_dc[k] = 0;
    end
  endtask

  task automatic model_edge();
    int lim, hi, lo;
    bit ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      e_ack[k] = 0; e_err[k] = 0; e_mc[k] = 0; e_hc[k] = 0; e_dc[k] = 0;
      e_lost[k] = tick && mp[k];
      if (set_en) begin
        lim = (set_sel == 2'd2) ? hmax[k] : 60;
        hi = int'(set_val[7:4]);
        lo = int'(set_val[3:0]);
        ok = set_sel != 2'd3 && hi <= 9 && lo <= 9 && hi * 10 + lo < lim;
        e_ack[k] = ok;
        e_err[k] = !ok;
        if (ok && set_sel == 2'd0) ms[k] = hi * 10 + lo;
        if (ok && set_sel == 2'd1) mm[k] = hi * 10 + lo;
        if (ok && set_sel == 2'd2) mh[k] = hi * 10 + lo;
        mp[k] = mp[k] || tick;
      end else if (tick || mp[k]) begin
        mp[k] = 0;
        ms[k] = (ms[k] + 1) % 60;
        if (ms[k] == 0) begin
          e_mc[k] = 1;
          mm[k] = (mm[k] + 1) % 60;
          if (mm[k] == 0) begin
            e_hc[k] = 1;
            mh[k] = (mh[k] + 1) % hmax[k];
            e_dc[k] = mh[k] == 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sec%0d", k), 32'(sec_o[k]), 32'(bcd(ms[k])));
      chk($sformatf("min%0d", k), 32'(min_o[k]), 32'(bcd(mm[k])));
      chk($sformatf("hour%0d", k), 32'(hour_o[k]), 32'(bcd(mh[k])));
      chk($sformatf("ack%0d", k), 32'(ack_o[k]), 32'(e_ack[k]));
      chk($sformatf("err%0d", k), 32'(err_o[k]), 32'(e_err[k]));
      chk($sformatf("lost%0d", k), 32'(lost_o[k]), 32'(e_lost[k]));
      chk($sformatf("mc%0d", k), 32'(mc_o[k]), 32'(e_mc[k]));
      chk($sformatf("hc%0d", k), 32'(hc_o[k]), 32'(e_hc[k]));
      chk($sformatf("dc%0d", k), 32'(dc_o[k]), 32'(e_dc[k]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_cyc(input logic [1:0] sel, input logic [7:0] val);
    set_en = 1'b1; set_sel = sel; set_val = val;
    cyc();
  endtask

  initial begin
    logic [1:0] bad_sel[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] bad_val[4] = '{8'h60, 8'h5A, 8'h24, 8'h00};
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick = 1'b1;
      cyc();
      if (mc_o[0]) begin
        cnt++;
        chk("mc_align_sec", 32'(sec_o[0]), 32'h00);
      end
      tick = 1'b0;
      repeat (9) begin
        cyc();
        if (mc_o[0]) cnt++;
      end
    end
    chk("mc_count", cnt, 1);
    chk("sec_after60", 32'(sec_o[0]), 32'h00);
    chk("min_after60", 32'(min_o[0]), 32'h01);

    set_cyc(2'd2, 8'h23);
    set_cyc(2'd1, 8'h59);
    set_cyc(2'd0, 8'h58);
    set_en = 1'b0; tick = 1'b1;
    cyc();
    chk("sec_59", 32'(sec_o[0]), 32'h59);
    cyc();
    chk("wrap_time", {8'h0, hour_o[0], min_o[0], sec_o[0]}, 32'h0);
    chk("wrap_carries", {mc_o[0], hc_o[0], dc_o[0]}, 3'b111);
    tick = 1'b0;
    cyc();

    for (int i = 0; i < 4; i++) begin
      set_cyc(bad_sel[i], bad_val[i]);
      chk("bad_set_err", 32'(err_o[0]), 1);
      chk("bad_set_time", {8'h0, hour_o[0], min_o[0], sec_o[0]}, 32'h0);
    end
    set_en = 1'b0;
    cyc();

    set_cyc(2'd0, 8'h10);
    tick = 1'b1;
    set_cyc(2'd0, 8'h10);
    tick = 1'b0;
    set_cyc(2'd0, 8'h10);
    chk("burst_sec", 32'(sec_o[0]), 32'h10);
    set_en = 1'b0;
    cyc();
    chk("release_sec", 32'(sec_o[0]), 32'h11);
    chk("release_lost", 32'(lost_o[0]), 0);
    cyc();

    cnt = 0;
    tick = 1'b1;
    set_cyc(2'd0, 8'h20);
    tick = 1'b0;
    set_cyc(2'd0, 8'h20);
    tick = 1'b1;
    set_cyc(2'd0, 8'h20);
    if (lost_o[0]) cnt++;
    tick = 1'b0; set_en = 1'b0;
    cyc();
    if (lost_o[0]) cnt++;
    chk("lost_count", cnt, 1);
    chk("two_tick_sec", 32'(sec_o[0]), 32'h21);
    cyc();

    set_cyc(2'd2, 8'h11);
    set_cyc(2'd1, 8'h59);
    set_cyc(2'd0, 8'h59);
    set_en = 1'b0; tick = 1'b1;
    cyc();
    chk("h12_time", {8'h0, hour_o[1], min_o[1], sec_o[1]}, 32'h0);
    chk("h12_day", 32'(dc_o[1]), 1);
    chk("h24_noon", 32'(hour_o[0]), 32'h12);
    tick = 1'b0;
    cyc();

    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 7) == 0);
      set_en = ($urandom_range(0, 5) == 0);
      set_sel = 2'($urandom_range(0, 3));
      set_val = $urandom_range(0, 1) ? bcd($urandom_range(0, 65)) : 8'($urandom);
      cyc();
      chk("ack_err_excl", 32'(ack_o[0] & err_o[0]), 0);
    end

    tick = 1'b1; set_en = 1'b1; set_sel = 2'd0; set_val = 8'h33;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc();
    #3;
    rst_n = 1'b1;
    tick = 1'b0; set_en = 1'b0;
    repeat (3) cyc();
    chk("no_pend_after_rst", 32'(sec_o[0]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
